ft_lookup_client: RTL

- Per-interface requester for the forwarding-table lookup interface, instantiated once per ingress interface next to the header parser.
- Takes a parsed header and drives a held lookup request into the forwarding table.
- Waits for the table's response, with a timeout, then presents a registered forwarding decision (egress port or drop, plus packet tag) to the output arbiter.
- Keeps one lookup outstanding at a time and maintains lookup and timeout statistics.

---
 rtl/sdn_pkg.sv | 15 +
 rtl/ft_timeout_timer.sv | 22 ++
 rtl/ft_lookup_client.sv | 104 ++++++++++
 3 files changed

// File: rtl/sdn_pkg.sv
// sdn_pkg: shared widths, FSM states, lookup header type and counter helper
package sdn_pkg;
  localparam int MAC_W = 48;
  localparam int IP_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT, DECIDE} state_e;
  typedef struct packed {
    logic [MAC_W-1:0] dest_mac;
    logic [MAC_W-1:0] src_mac;
    logic [IP_W-1:0]  dest_ip;
    logic [IP_W-1:0]  src_ip;
  } lookup_hdr_t;
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/ft_timeout_timer.sv
// ft_timeout_timer: loadable cycle counter with clear, enable and terminal-count flag
module ft_timeout_timer #(
  parameter int W = 16,
  parameter logic [W-1:0] TERMINAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);
  logic [W-1:0] count;
  // clear beats load, load beats counting
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= count + 1'b1;
  assign tc = count == TERMINAL;
endmodule

// File: rtl/ft_lookup_client.sv
// ft_lookup_client: per-interface forwarding-table requester with timeout and decision output
module ft_lookup_client
  import sdn_pkg::*;
#(
  parameter int NUM_INTERFACES = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TAG_W = 8,
  localparam int PORT_W = $clog2(NUM_INTERFACES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hdr_valid,
  output logic              o_hdr_ready,
  input  logic [MAC_W-1:0]  i_dest_mac,
  input  logic [MAC_W-1:0]  i_src_mac,
  input  logic [IP_W-1:0]   i_dest_ip,
  input  logic [IP_W-1:0]   i_src_ip,
  input  logic [TAG_W-1:0]  i_pkt_tag,
  output logic              o_ft_hdr_valid,
  output logic [MAC_W-1:0]  o_ft_dest_mac,
  output logic [MAC_W-1:0]  o_ft_src_mac,
  output logic [IP_W-1:0]   o_ft_dest_ip,
  output logic [IP_W-1:0]   o_ft_src_ip,
  input  logic              i_ft_resp_valid,
  input  logic [PORT_W-1:0] i_ft_resp,
  input  logic              i_ft_drop_packet,
  output logic              o_dec_valid,
  input  logic              i_dec_ready,
  output logic [PORT_W-1:0] o_dec_port,
  output logic              o_dec_drop,
  output logic              o_dec_timeout,
  output logic [TAG_W-1:0]  o_dec_tag,
  output logic [31:0]       o_lookup_cnt,
  output logic [15:0]       o_timeout_cnt
);
  localparam logic [15:0] TERM = 16'(TIMEOUT_CYCLES - 1);
  state_e state;
  lookup_hdr_t hdr_q;
  logic accept, tmr_tc, resp_oor;
  assign accept = state == IDLE && i_hdr_valid && o_hdr_ready;
  assign resp_oor = 32'(i_ft_resp) >= 32'(NUM_INTERFACES);
  assign o_ft_dest_mac = hdr_q.dest_mac;
  assign o_ft_src_mac = hdr_q.src_mac;
  assign o_ft_dest_ip = hdr_q.dest_ip;
  assign o_ft_src_ip = hdr_q.src_ip;
  ft_timeout_timer #(.W(16), .TERMINAL(TERM)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .load(1'b0),
    .load_val(16'd0),
    .en(state == WAIT),
    .tc(tmr_tc)
  );
  // lookup FSM: accept header, hold request until response or timeout, hold decision until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hdr_q <= '0;
      o_hdr_ready <= 1'b0;
      o_ft_hdr_valid <= 1'b0;
      o_dec_valid <= 1'b0;
      o_dec_port <= '0;
      o_dec_drop <= 1'b0;
      o_dec_timeout <= 1'b0;
      o_dec_tag <= '0;
      o_lookup_cnt <= '0;
      o_timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_hdr_ready <= 1'b1;
          if (accept) begin
            hdr_q <= '{dest_mac: i_dest_mac, src_mac: i_src_mac, dest_ip: i_dest_ip, src_ip: i_src_ip};
            o_dec_tag <= i_pkt_tag;
            o_hdr_ready <= 1'b0;
            o_ft_hdr_valid <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (i_ft_resp_valid || tmr_tc) begin
            o_dec_port <= i_ft_resp_valid ? i_ft_resp : '0;
            o_dec_drop <= i_ft_resp_valid ? (i_ft_drop_packet | resp_oor) : 1'b1;
            o_dec_timeout <= !i_ft_resp_valid;
            o_timeout_cnt <= i_ft_resp_valid ? o_timeout_cnt : sat_inc16(o_timeout_cnt);
            o_ft_hdr_valid <= 1'b0;
            o_dec_valid <= 1'b1;
            state <= DECIDE;
          end
        end
        DECIDE: begin
          if (i_dec_ready) begin
            o_dec_valid <= 1'b0;
            o_lookup_cnt <= o_lookup_cnt + 32'd1;
            o_hdr_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
